// File: rtl/eth_csr_avmm_arb.sv
// -----------------------------------------------------------------------------
// eth_csr_avmm_arb
//
// Round-robin arbiter that lets NUM_REQ CSR requesters share one Avalon-MM
// downstream port. Exactly one downstream command is outstanding at a time.
// Each command is guarded by a wait-cycle timeout, so a stuck slave cannot
// hang a requester.
//
// Ports
//   clk                 sole clock
//   rst_n               synchronous, active-low reset
//   i_req_read          per-requester read strobe            [NUM_REQ]
//   i_req_write         per-requester write strobe           [NUM_REQ]
//   i_req_addr          packed addresses, requester i in slice i
//   i_req_wdata         packed write data, requester i in slice i
//   o_req_waitrequest   per-requester, low only in the accept cycle
//   o_req_rdata         shared read data, held between completions
//   o_req_rdvalid       one-cycle read completion pulse      [NUM_REQ]
//   o_req_wrdone        one-cycle write completion pulse     [NUM_REQ]
//   o_avmm_*            downstream Avalon-MM master
//   i_avmm_readdata     downstream read data
//   i_avmm_waitrequest  downstream stall
//   o_timeout_err       one-cycle pulse when a command times out
//   o_err_cnt           saturating count of timeouts
//   o_busy              high while a command is in flight
// -----------------------------------------------------------------------------
module eth_csr_avmm_arb #(
    parameter int NUM_REQ     = 2,
    parameter int AVMM_ADDR_W = 16,
    parameter int AVMM_DATA_W = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             i_req_read,
    input  logic [NUM_REQ-1:0]             i_req_write,
    input  logic [NUM_REQ*AVMM_ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*AVMM_DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]             o_req_waitrequest,
    output logic [AVMM_DATA_W-1:0]         o_req_rdata,
    output logic [NUM_REQ-1:0]             o_req_rdvalid,
    output logic [NUM_REQ-1:0]             o_req_wrdone,

    output logic [AVMM_ADDR_W-1:0]         o_avmm_addr,
    output logic                           o_avmm_read,
    output logic                           o_avmm_write,
    output logic [AVMM_DATA_W-1:0]         o_avmm_writedata,
    input  logic [AVMM_DATA_W-1:0]         i_avmm_readdata,
    input  logic                           i_avmm_waitrequest,

    output logic                           o_timeout_err,
    output logic [15:0]                    o_err_cnt,
    output logic                           o_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       cur_idx;
    logic                   op_write;
    logic [CNT_W-1:0]       wait_cnt;
    logic [CNT_W-1:0]       wait_cnt_nxt;
    logic [AVMM_ADDR_W-1:0] cmd_addr;
    logic [AVMM_DATA_W-1:0] cmd_wdata;

    logic [NUM_REQ-1:0]     req_any;
    logic                   grant_valid;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       cand_idx;
    logic                   accept;
    logic [PTR_W-1:0]       next_ptr;
    logic [AVMM_ADDR_W-1:0] sel_addr;
    logic [AVMM_DATA_W-1:0] sel_wdata;

    assign req_any = i_req_read | i_req_write;

    // Round-robin search: the first requester at or after rr_ptr wins.
    // NOTE: every variable driven here gets a default before any condition so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_valid && req_any[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Grants are decided combinationally from the live strobes, so a
    // requester that drops its strobe before this cycle is simply not seen.
    // Gating with rst_n keeps waitrequest all-ones while reset is held.
    assign accept = rst_n && (state == ST_IDLE) && grant_valid;

    always_comb begin
        o_req_waitrequest = '1;
        if (accept) begin
            o_req_waitrequest[grant_idx] = 1'b0;
        end
    end

    // Select the winner's address/data slice.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_addr  = i_req_addr[i*AVMM_ADDR_W +: AVMM_ADDR_W];
                sel_wdata = i_req_wdata[i*AVMM_DATA_W +: AVMM_DATA_W];
            end
        end
    end

    assign next_ptr     = (cur_idx == PTR_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
    assign wait_cnt_nxt = wait_cnt + 1'b1;

    // Control path: FSM, arbitration pointer, completion pulses, error count.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            cur_idx       <= '0;
            op_write      <= 1'b0;
            wait_cnt      <= '0;
            o_req_rdata   <= '0;
            o_req_rdvalid <= '0;
            o_req_wrdone  <= '0;
            o_timeout_err <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            o_req_rdvalid <= '0;
            o_req_wrdone  <= '0;
            o_timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_ISSUE;
                        cur_idx  <= grant_idx;
                        // Read+write together is treated as a write.
                        op_write <= i_req_write[grant_idx];
                        wait_cnt <= '0;
                    end
                end

                ST_ISSUE: begin
                    if (!i_avmm_waitrequest) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_ptr;
                        if (op_write) begin
                            o_req_wrdone[cur_idx] <= 1'b1;
                        end else begin
                            o_req_rdvalid[cur_idx] <= 1'b1;
                            o_req_rdata            <= i_avmm_readdata;
                        end
                    end else if (wait_cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
                        // Abort: the requester still gets its completion
                        // pulse so it is never left waiting, with all-ones
                        // read data flagging the failed read.
                        state         <= ST_IDLE;
                        rr_ptr        <= next_ptr;
                        o_timeout_err <= 1'b1;
                        if (op_write) begin
                            o_req_wrdone[cur_idx] <= 1'b1;
                        end else begin
                            o_req_rdvalid[cur_idx] <= 1'b1;
                            o_req_rdata            <= '1;
                        end
                        if (o_err_cnt != 16'hFFFF) begin
                            o_err_cnt <= o_err_cnt + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command address/data latch.
    // NOTE: left without reset; it is only observed while state is ISSUE,
    // which always follows a load, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
        end
    end

    // Strobes come straight from state, so they are held for the whole
    // ISSUE phase and are mutually exclusive by construction.
    assign o_avmm_read      = (state == ST_ISSUE) && !op_write;
    assign o_avmm_write     = (state == ST_ISSUE) &&  op_write;
    assign o_avmm_addr      = cmd_addr;
    assign o_avmm_writedata = cmd_wdata;
    assign o_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_csr_avmm_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_csr_avmm_arb
//
// Self-checking bench for eth_csr_avmm_arb (3 requesters, TIMEOUT_CYC = 8).
// Directed scenarios cover reset, single read, contention, backpressure,
// timeout, reset mid-command and read+write collision; a randomized phase
// compares every cycle against a transaction-level reference model.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_eth_csr_avmm_arb;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_read, req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_waitrequest, req_rdvalid, req_wrdone;
    logic [DW-1:0]    req_rdata;
    logic [AW-1:0]    avmm_addr;
    logic             avmm_read, avmm_write;
    logic [DW-1:0]    avmm_writedata, avmm_readdata;
    logic             avmm_waitrequest;
    logic             timeout_err;
    logic [15:0]      err_cnt;
    logic             busy;

    int errors = 0;
    int checks = 0;

    eth_csr_avmm_arb #(
        .NUM_REQ(NR), .AVMM_ADDR_W(AW), .AVMM_DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_read(req_read), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_waitrequest(req_waitrequest), .o_req_rdata(req_rdata),
        .o_req_rdvalid(req_rdvalid), .o_req_wrdone(req_wrdone),
        .o_avmm_addr(avmm_addr), .o_avmm_read(avmm_read), .o_avmm_write(avmm_write),
        .o_avmm_writedata(avmm_writedata), .i_avmm_readdata(avmm_readdata),
        .i_avmm_waitrequest(avmm_waitrequest),
        .o_timeout_err(timeout_err), .o_err_cnt(err_cnt), .o_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        req_read         = '0;
        req_write        = '0;
        req_addr         = '0;
        req_wdata        = '0;
        avmm_readdata    = '0;
        avmm_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_read = 3'b111;   // requests during reset must not be accepted
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if ({avmm_read, avmm_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {avmm_read, avmm_write}); end
            checks++; if (req_waitrequest !== 3'b111) begin errors++; $display("FAIL reset_waitreq: got %b want 111", req_waitrequest); end
            checks++; if ({req_rdvalid, req_wrdone, timeout_err} !== 7'd0) begin errors++; $display("FAIL reset_pulses: got %b want 0", {req_rdvalid, req_wrdone, timeout_err}); end
            checks++; if (req_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", req_rdata); end
            checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_read = '0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req_read[0] = 1'b1;
        req_addr[0*AW +: AW] = 16'h0010;
        avmm_waitrequest = 1'b0;
        avmm_readdata = 32'hCAFE_0001;
        @(negedge clk);
        checks++; if (req_waitrequest !== 3'b110) begin errors++; $display("FAIL sr_accept: got %b want 110", req_waitrequest); end
        @(posedge clk); #1;
        req_read = '0;
        @(negedge clk);
        checks++; if ({avmm_read, avmm_write, busy} !== 3'b101) begin errors++; $display("FAIL sr_strobe: got rd/wr/busy %b want 101", {avmm_read, avmm_write, busy}); end
        checks++; if (avmm_addr !== 16'h0010) begin errors++; $display("FAIL sr_addr: got %h want 0010", avmm_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_rdvalid !== 3'b001) begin errors++; $display("FAIL sr_rdvalid: got %b want 001", req_rdvalid); end
        checks++; if (req_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL sr_rdata: got %h want cafe0001", req_rdata); end
        checks++; if ({avmm_read, busy} !== 2'b00) begin errors++; $display("FAIL sr_idle: got rd/busy %b want 00", {avmm_read, busy}); end
        @(posedge clk); #1;
        avmm_readdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++; if (req_rdvalid !== 3'b000) begin errors++; $display("FAIL sr_pulse_len: got %b want 000", req_rdvalid); end
        checks++; if (req_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL sr_rdata_hold: got %h want cafe0001", req_rdata); end
    endtask

    task automatic test_contention();
        int grants[$];
        int dones[$];
        int last_g;
        last_g = -1;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                req_write = 3'b011;
                req_addr[0*AW +: AW]  = 16'h0100;
                req_addr[1*AW +: AW]  = 16'h0101;
                req_wdata[0*DW +: DW] = 32'h0000_00A0;
                req_wdata[1*DW +: DW] = 32'h0000_00B1;
            end
            if (c == 14) req_write = '0;
            @(negedge clk);
            checks++; if (avmm_read && avmm_write) begin errors++; $display("FAIL ct_both_strobes: got 11 want not 11"); end
            for (int i = 0; i < NR; i++) begin
                if (req_waitrequest[i] == 1'b0) begin grants.push_back(i); last_g = i; end
                if (req_wrdone[i]) dones.push_back(i);
            end
            if (avmm_write) begin
                checks++;
                if (avmm_writedata !== ((last_g == 0) ? 32'h0000_00A0 : 32'h0000_00B1)) begin
                    errors++; $display("FAIL ct_wdata: got %h for grant %0d", avmm_writedata, last_g);
                end
            end
        end
        checks++; if (grants.size() < 4) begin errors++; $display("FAIL ct_grant_count: got %0d want >=4", grants.size()); end
        checks++; if (dones.size() != grants.size()) begin errors++; $display("FAIL ct_done_count: got %0d want %0d", dones.size(), grants.size()); end
        for (int k = 0; k < 4 && k < grants.size() && k < dones.size(); k++) begin
            checks++; if (grants[k] != k % 2) begin errors++; $display("FAIL ct_grant_order[%0d]: got %0d want %0d", k, grants[k], k % 2); end
            checks++; if (dones[k] != k % 2) begin errors++; $display("FAIL ct_done_order[%0d]: got %0d want %0d", k, dones[k], k % 2); end
        end
    endtask

    task automatic test_backpressure();
        int stable;
        stable = 0;
        @(posedge clk); #1;
        req_write[0] = 1'b1;
        req_addr[0*AW +: AW]  = 16'h0040;
        req_wdata[0*DW +: DW] = 32'h1234_5678;
        avmm_waitrequest = 1'b1;
        @(negedge clk);
        checks++; if (req_waitrequest !== 3'b110) begin errors++; $display("FAIL bp_accept: got %b want 110", req_waitrequest); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            req_write = '0;
            avmm_waitrequest = (k < 5);
            @(negedge clk);
            if (avmm_write && avmm_addr === 16'h0040 && avmm_writedata === 32'h1234_5678) stable++;
            checks++; if (req_wrdone !== 3'b000) begin errors++; $display("FAIL bp_early_done[%0d]: got %b want 000", k, req_wrdone); end
        end
        checks++; if (stable != 6) begin errors++; $display("FAIL bp_stable: got %0d cycles want 6", stable); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_wrdone !== 3'b001) begin errors++; $display("FAIL bp_wrdone: got %b want 001", req_wrdone); end
        checks++; if (avmm_write !== 1'b0) begin errors++; $display("FAIL bp_strobe_drop: got %b want 0", avmm_write); end
    endtask

    task automatic test_timeout();
        int strobe_cycles;
        strobe_cycles = 0;
        @(posedge clk); #1;
        req_read[1] = 1'b1;
        req_addr[1*AW +: AW] = 16'h0200;
        avmm_waitrequest = 1'b1;
        @(negedge clk);
        checks++; if (req_waitrequest !== 3'b101) begin errors++; $display("FAIL to_accept: got %b want 101", req_waitrequest); end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            req_read = '0;
            @(negedge clk);
            if (!avmm_read) break;
            strobe_cycles++;
        end
        checks++; if (strobe_cycles != TO) begin errors++; $display("FAIL to_strobe_cycles: got %0d want %0d", strobe_cycles, TO); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b want 1", timeout_err); end
        checks++; if (req_rdvalid !== 3'b010) begin errors++; $display("FAIL to_rdvalid: got %b want 010", req_rdvalid); end
        checks++; if (req_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata: got %h want ffffffff", req_rdata); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL to_errcnt: got %0d want 1", err_cnt); end
        @(posedge clk); #1;
        avmm_waitrequest = 1'b0;
        @(negedge clk);
        checks++; if ({timeout_err, req_rdvalid} !== 4'b0000) begin errors++; $display("FAIL to_pulse_len: got %b want 0000", {timeout_err, req_rdvalid}); end
    endtask

    task automatic test_reset_mid_issue();
        @(posedge clk); #1;
        req_read[0] = 1'b1;
        req_addr[0*AW +: AW] = 16'h0300;
        avmm_waitrequest = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_read = '0;
            @(negedge clk);
        end
        checks++; if (avmm_read !== 1'b1) begin errors++; $display("FAIL rm_stalled: got %b want 1", avmm_read); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({avmm_read, busy} !== 2'b00) begin errors++; $display("FAIL rm_abort: got rd/busy %b want 00", {avmm_read, busy}); end
        checks++; if ({req_rdvalid, timeout_err} !== 4'b0000) begin errors++; $display("FAIL rm_no_pulse: got %b want 0000", {req_rdvalid, timeout_err}); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rm_errcnt: got %0d want 0", err_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        avmm_waitrequest = 1'b0;
        req_read = 3'b111;
        req_addr[0*AW +: AW] = 16'h0A00;
        req_addr[1*AW +: AW] = 16'h0A01;
        req_addr[2*AW +: AW] = 16'h0A02;
        @(negedge clk);
        checks++; if (req_waitrequest !== 3'b110) begin errors++; $display("FAIL rm_first_grant: got %b want 110", req_waitrequest); end
        @(posedge clk); #1;
        req_read = '0;
        @(negedge clk);
        checks++; if (avmm_addr !== 16'h0A00) begin errors++; $display("FAIL rm_grant_addr: got %h want 0a00", avmm_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_rdvalid !== 3'b001) begin errors++; $display("FAIL rm_rdvalid: got %b want 001", req_rdvalid); end
    endtask

    task automatic test_read_write_same();
        @(posedge clk); #1;
        req_read[1]  = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1*AW +: AW]  = 16'h0055;
        req_wdata[1*DW +: DW] = 32'hA5A5_A5A5;
        avmm_waitrequest = 1'b0;
        @(negedge clk);
        checks++; if (req_waitrequest !== 3'b101) begin errors++; $display("FAIL rw_accept: got %b want 101", req_waitrequest); end
        @(posedge clk); #1;
        req_read  = '0;
        req_write = '0;
        @(negedge clk);
        checks++; if ({avmm_read, avmm_write} !== 2'b01) begin errors++; $display("FAIL rw_strobes: got rd/wr %b want 01", {avmm_read, avmm_write}); end
        checks++; if (avmm_writedata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rw_wdata: got %h want a5a5a5a5", avmm_writedata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_wrdone !== 3'b010) begin errors++; $display("FAIL rw_wrdone: got %b want 010", req_wrdone); end
        checks++; if (req_rdvalid !== 3'b000) begin errors++; $display("FAIL rw_no_rdvalid: got %b want 000", req_rdvalid); end
    endtask

    // Randomized traffic against a transaction-level reference model.
    task automatic test_random();
        // requester-side behaviour
        bit            act[NR];
        bit            a_rd[NR], a_wr[NR];
        logic [AW-1:0] a_addr[NR];
        logic [DW-1:0] a_data[NR];
        int            stall;
        // reference model: at most one command in flight
        bit            m_busy;
        int            m_g, m_waits, m_rr, m_err;
        bit            m_wr;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data, m_rdata;
        logic [NR-1:0] e_rdv, e_wrd, e_wreq;
        bit            e_to;
        int            w, j;

        do_reset();
        for (int i = 0; i < NR; i++) begin act[i] = 0; a_rd[i] = 0; a_wr[i] = 0; a_addr[i] = '0; a_data[i] = '0; end
        stall = 0;
        m_busy = 0; m_g = 0; m_waits = 0; m_rr = 0; m_err = 0; m_wr = 0;
        m_addr = '0; m_data = '0; m_rdata = '0;
        e_rdv = '0; e_wrd = '0; e_to = 0;

        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1;
                    case ($urandom_range(0, 2))
                        0:       begin a_rd[i] = 1; a_wr[i] = 0; end
                        1:       begin a_rd[i] = 0; a_wr[i] = 1; end
                        default: begin a_rd[i] = 1; a_wr[i] = 1; end
                    endcase
                    a_addr[i] = AW'($urandom);
                    a_data[i] = $urandom;
                end else if (act[i] && $urandom_range(0, 19) == 0) begin
                    act[i] = 0;   // withdraw before being accepted
                end
                req_read[i]  = act[i] & a_rd[i];
                req_write[i] = act[i] & a_wr[i];
                req_addr[i*AW +: AW]  = a_addr[i];
                req_wdata[i*DW +: DW] = a_data[i];
            end
            if (stall > 0) begin
                avmm_waitrequest = 1'b1;
                stall--;
            end else begin
                avmm_waitrequest = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 29) == 0) stall = 12;
            end
            avmm_readdata = $urandom;
            @(negedge clk);

            w = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    j = (m_rr + k) % NR;
                    if (w < 0 && (req_read[j] || req_write[j])) w = j;
                end
            end
            e_wreq = '1;
            if (w >= 0) e_wreq[w] = 1'b0;

            checks++; if (req_waitrequest !== e_wreq) begin errors++; $display("FAIL rnd_waitreq c%0d: got %b want %b", c, req_waitrequest, e_wreq); end
            checks++; if ({avmm_read, avmm_write} !== {m_busy && !m_wr, m_busy && m_wr}) begin errors++; $display("FAIL rnd_strobes c%0d: got %b want %b", c, {avmm_read, avmm_write}, {m_busy && !m_wr, m_busy && m_wr}); end
            if (m_busy) begin
                checks++; if (avmm_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, avmm_addr, m_addr); end
                if (m_wr) begin
                    checks++; if (avmm_writedata !== m_data) begin errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, avmm_writedata, m_data); end
                end
            end
            checks++; if (req_rdvalid !== e_rdv) begin errors++; $display("FAIL rnd_rdvalid c%0d: got %b want %b", c, req_rdvalid, e_rdv); end
            checks++; if (req_wrdone !== e_wrd) begin errors++; $display("FAIL rnd_wrdone c%0d: got %b want %b", c, req_wrdone, e_wrd); end
            checks++; if (req_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, req_rdata, m_rdata); end
            checks++; if (timeout_err !== e_to) begin errors++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, timeout_err, e_to); end
            checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL rnd_errcnt c%0d: got %0d want %0d", c, err_cnt, m_err); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); end

            // advance the model across the coming clock edge
            e_rdv = '0; e_wrd = '0; e_to = 0;
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy  = 1;
                    m_g     = w;
                    m_wr    = req_write[w];
                    m_addr  = a_addr[w];
                    m_data  = a_data[w];
                    m_waits = 0;
                    act[w]  = 0;
                end
            end else if (!avmm_waitrequest) begin
                if (m_wr) e_wrd[m_g] = 1'b1;
                else begin e_rdv[m_g] = 1'b1; m_rdata = avmm_readdata; end
                m_busy = 0;
                m_rr   = (m_g + 1) % NR;
            end else begin
                m_waits++;
                if (m_waits == TO) begin
                    e_to = 1;
                    if (m_wr) e_wrd[m_g] = 1'b1;
                    else begin e_rdv[m_g] = 1'b1; m_rdata = '1; end
                    if (m_err < 65535) m_err++;
                    m_busy = 0;
                    m_rr   = (m_g + 1) % NR;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_read_write_same();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
